// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and condition-code indices
// for the mini ALU issue controller.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDX = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SUBX = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXEC_LO = 2'b01,
    EXEC_HI = 2'b10,
    RESP    = 2'b11
  } seq_state_t;

  function automatic logic is_add(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADDX);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SUBX);
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_SLL) && (op <= OP_SRA);
  endfunction

  function automatic logic uses_cin(input logic [3:0] op);
    return (op == OP_ADDX) || (op == OP_SUBX);
  endfunction

  // Upper-word pass turns add/sub into its carry-consuming form.
  function automatic logic [3:0] hi_op(input logic [3:0] op);
    logic [3:0] r;
    r = op;
    if (is_add(op)) r = OP_ADDX;
    if (is_sub(op)) r = OP_SUBX;
    return r;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Carry/borrow and signed-overflow derivation for one
// ALU pass, from the operands driven and the result.
module alu_flag_gen
  import alu_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   i_opcode,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c1,
  input  logic [W-1:0] i_y,
  output logic         o_cout,
  output logic         o_v
);

  logic w_a_msb;
  logic w_b_msb;
  logic w_y_msb;

  assign w_a_msb = i_a[W-1];
  assign w_b_msb = i_b[W-1];
  assign w_y_msb = i_y[W-1];

  always_comb begin
    o_cout = 1'b0;
    o_v    = 1'b0;
    if (is_add(i_opcode)) begin
      o_cout = (i_y < i_a) | (i_c1 & (i_y == i_a));
      o_v    = (w_a_msb == w_b_msb) & (w_y_msb != w_a_msb);
    end else if (is_sub(i_opcode)) begin
      o_cout = (i_a < i_b) | (i_c1 & (i_a == i_b));
      o_v    = (w_a_msb != w_b_msb) & (w_y_msb != w_a_msb);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue controller for the mini ALU: single/double-width
// passes, carry chaining and N/Z/V/C generation.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           Clk,
  input  logic           Clr,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [3:0]     req_op,
  input  logic           req_dbl,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_c1,
  output logic [3:0]     alu_opcode,
  input  logic [W-1:0]   alu_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_y,
  output logic           rsp_err,
  output logic [3:0]     icc
);

  seq_state_t     r_state;
  logic           r_req_ready;
  logic [3:0]     r_op;
  logic           r_dbl;
  logic [W-1:0]   r_a_hi;
  logic [W-1:0]   r_b_hi;
  logic [W-1:0]   r_alu_a;
  logic [W-1:0]   r_alu_b;
  logic           r_alu_c1;
  logic [3:0]     r_alu_opcode;
  logic           r_rsp_valid;
  logic           r_rsp_err;
  logic [2*W-1:0] r_rsp_y;
  logic [3:0]     r_icc;

  logic w_cout;
  logic w_v;
  logic w_illegal;
  logic w_y_zero;
  logic w_lo_zero;

  assign w_illegal = req_dbl & is_shift(req_op);
  assign w_y_zero  = (alu_y == '0);
  assign w_lo_zero = (r_rsp_y[W-1:0] == '0);

  alu_flag_gen #(
    .W(W)
  ) u_flags (
    .i_opcode (r_alu_opcode),
    .i_a      (r_alu_a),
    .i_b      (r_alu_b),
    .i_c1     (r_alu_c1),
    .i_y      (alu_y),
    .o_cout   (w_cout),
    .o_v      (w_v)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_op         <= '0;
      r_dbl        <= 1'b0;
      r_a_hi       <= '0;
      r_b_hi       <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_c1     <= 1'b0;
      r_alu_opcode <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_y      <= '0;
      r_icc        <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_op        <= req_op;
            r_dbl       <= req_dbl;
            r_a_hi      <= req_a[2*W-1:W];
            r_b_hi      <= req_b[2*W-1:W];
            r_rsp_y     <= '0;
            if (w_illegal) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state      <= EXEC_LO;
              r_rsp_err    <= 1'b0;
              r_alu_a      <= req_a[W-1:0];
              r_alu_b      <= req_b[W-1:0];
              r_alu_opcode <= req_op;
              r_alu_c1     <= uses_cin(req_op)
                              & r_icc[ICC_C];
            end
          end
        end
        EXEC_LO: begin
          r_rsp_y[W-1:0] <= alu_y;
          if (r_dbl) begin
            r_state      <= EXEC_HI;
            r_alu_a      <= r_a_hi;
            r_alu_b      <= r_b_hi;
            r_alu_opcode <= hi_op(r_op);
            r_alu_c1     <= (is_add(r_op) | is_sub(r_op))
                            & w_cout;
          end else begin
            r_state      <= RESP;
            r_rsp_valid  <= 1'b1;
            r_icc        <= {alu_y[W-1], w_y_zero,
                             w_v, w_cout};
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_c1     <= 1'b0;
            r_alu_opcode <= '0;
          end
        end
        EXEC_HI: begin
          r_rsp_y[2*W-1:W] <= alu_y;
          r_state      <= RESP;
          r_rsp_valid  <= 1'b1;
          r_icc        <= {alu_y[W-1], w_y_zero & w_lo_zero,
                           w_v, w_cout};
          r_alu_a      <= '0;
          r_alu_b      <= '0;
          r_alu_c1     <= 1'b0;
          r_alu_opcode <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_c1     = r_alu_c1;
  assign alu_opcode = r_alu_opcode;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_y      = r_rsp_y;
  assign icc        = r_icc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a
// behavioural mini ALU closing the alu_* loop.
module tb_alu_op_sequencer;

  typedef struct {
    logic [63:0] y;
    logic        err;
    logic [3:0]  icc;
  } exp_t;

  logic        Clk;
  logic        Clr;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_dbl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_c1;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_y;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_y;
  logic        rsp_err;
  logic [3:0]  icc;

  int   n_checks;
  int   n_errors;
  exp_t q[$];
  logic [3:0] m_icc;

  alu_op_sequencer #(.W(32)) dut (
    .Clk        (Clk),
    .Clr        (Clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_dbl    (req_dbl),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c1     (alu_c1),
    .alu_opcode (alu_opcode),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_y      (rsp_y),
    .rsp_err    (rsp_err),
    .icc        (icc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    alu_y = '0;
    case (alu_opcode)
      4'b0000: alu_y = alu_a + alu_b;
      4'b0001: alu_y = alu_a + alu_b + {31'b0, alu_c1};
      4'b0010: alu_y = alu_a - alu_b;
      4'b0011: alu_y = alu_a - alu_b - {31'b0, alu_c1};
      4'b0100: alu_y = alu_a & alu_b;
      4'b1010: alu_y = alu_a << alu_b[4:0];
      4'b1011: alu_y = alu_a >> alu_b[4:0];
      4'b1100: alu_y = $signed(alu_a) >>> alu_b[4:0];
      default: alu_y = alu_a;
    endcase
  end

  function automatic exp_t model(input logic [3:0] op,
                                 input logic dbl,
                                 input logic [63:0] a_in,
                                 input logic [63:0] b_in,
                                 input logic [3:0] ic);
    exp_t e;
    logic [64:0] r;
    logic [63:0] a, b, y;
    logic cin, v, c, arith;
    int msb;
    msb = dbl ? 63 : 31;
    a = dbl ? a_in : {32'h0, a_in[31:0]};
    b = dbl ? b_in : {32'h0, b_in[31:0]};
    cin = (op == 4'b0001 || op == 4'b0011) ? ic[0] : 1'b0;
    v = 1'b0;
    c = 1'b0;
    arith = 1'b0;
    e.err = 1'b0;
    if (dbl && op >= 4'b1010 && op <= 4'b1100) begin
      e.y = '0;
      e.err = 1'b1;
      e.icc = ic;
      return e;
    end
    case (op)
      4'b0000, 4'b0001: begin
        r = {1'b0, a} + {1'b0, b} + {64'b0, cin};
        v = (a[msb] == b[msb]) && (r[msb] != a[msb]);
        arith = 1'b1;
      end
      4'b0010, 4'b0011: begin
        r = {1'b0, a} - {1'b0, b} - {64'b0, cin};
        v = (a[msb] != b[msb]) && (r[msb] != a[msb]);
        arith = 1'b1;
      end
      4'b0100: r = {1'b0, a & b};
      default: r = {1'b0, a};
    endcase
    y = dbl ? r[63:0] : {32'h0, r[31:0]};
    if (arith) c = r[msb+1];
    e.y = y;
    e.icc = {y[msb], (y == 64'h0), v, c};
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op,
                      input logic dbl,
                      input logic [63:0] a,
                      input logic [63:0] b);
    int t;
    exp_t e;
    t = 0;
    while (req_ready !== 1'b1 && t < 20) begin
      @(posedge Clk);
      #1;
      t++;
    end
    chk("req_ready_wait", {63'b0, req_ready}, 64'd1);
    req_op = op;
    req_dbl = dbl;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    e = model(op, dbl, a, b, m_icc);
    if (!e.err) m_icc = e.icc;
    q.push_back(e);
    @(posedge Clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, input string tag);
    int t;
    exp_t e;
    t = 0;
    rsp_ready = 1'b0;
    while (rsp_valid !== 1'b1 && t < 20) begin
      @(posedge Clk);
      #1;
      t++;
    end
    chk({tag, "_valid"}, {63'b0, rsp_valid}, 64'd1);
    if (q.size() > 0) e = q.pop_front();
    else begin
      e.y = 'x;
      e.err = 1'bx;
      e.icc = 'x;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      chk({tag, "_hold_valid"}, {63'b0, rsp_valid}, 64'd1);
      chk({tag, "_hold_rdy"}, {63'b0, req_ready}, 64'd0);
      chk({tag, "_hold_y"}, rsp_y, e.y);
    end
    chk({tag, "_y"}, rsp_y, e.y);
    chk({tag, "_err"}, {63'b0, rsp_err}, {63'b0, e.err});
    chk({tag, "_icc"}, {60'b0, icc}, {60'b0, e.icc});
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, {63'b0, rsp_valid}, 64'd0);
    chk({tag, "_idle"}, {63'b0, req_ready}, 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_icc = 4'b0000;
    Clr = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_dbl = 1'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", {63'b0, rsp_valid}, 64'd0);
    chk("rst_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_icc", {60'b0, icc}, 64'd0);
    chk("rst_y", rsp_y, 64'd0);
    chk("rst_opc", {60'b0, alu_opcode}, 64'd0);
    @(negedge Clk);
    Clr = 1'b0;
    @(posedge Clk);
    #1;

    // single add, junk in the unused upper operand bits
    send(4'b0000, 1'b0, 64'hDEAD0000_00000005, 64'h00000007);
    chk("add_lo_alu_a", {32'b0, alu_a}, 64'd5);
    chk("add_lat1", {63'b0, rsp_valid}, 64'd0);
    @(posedge Clk);
    #1;
    chk("add_lat2", {63'b0, rsp_valid}, 64'd1);
    get_rsp(0, "add");

    // double add with carry from the low word
    send(4'b0000, 1'b1, 64'h00000000_FFFFFFFF, 64'h1);
    chk("dadd_lo_opc", {60'b0, alu_opcode}, 64'd0);
    @(posedge Clk);
    #1;
    chk("dadd_hi_opc", {60'b0, alu_opcode}, 64'd1);
    chk("dadd_hi_c1", {63'b0, alu_c1}, 64'd1);
    get_rsp(0, "dadd");

    send(4'b0010, 1'b0, 64'h0, 64'h1);
    get_rsp(0, "sub_borrow");

    // illegal shift under backpressure, icc must survive
    send(4'b1010, 1'b1, 64'h1234, 64'h4);
    get_rsp(5, "illegal");

    send(4'b0001, 1'b0, 64'h2, 64'h3);
    chk("addx_c1", {63'b0, alu_c1}, 64'd1);
    get_rsp(0, "addx");

    send(4'b0000, 1'b0, 64'h7FFFFFFF, 64'h1);
    get_rsp(0, "ovf");

    send(4'b0010, 1'b1, 64'h00000001_00000000, 64'h1);
    get_rsp(0, "dsub");

    send(4'b0100, 1'b1, 64'hF0F0F0F0_12345678,
         64'hFF00FF00_0F0F0F0F);
    get_rsp(0, "dand");

    send(4'b0000, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h1);
    get_rsp(0, "dzero");

    // reset in EXEC_HI drops the request
    send(4'b0000, 1'b1, 64'h5_00000003, 64'h6_00000004);
    @(posedge Clk);
    #1;
    chk("abort_in_hi", {60'b0, alu_opcode}, 64'd1);
    Clr = 1'b1;
    #1;
    chk("abort_valid", {63'b0, rsp_valid}, 64'd0);
    chk("abort_icc", {60'b0, icc}, 64'd0);
    chk("abort_ready", {63'b0, req_ready}, 64'd1);
    chk("abort_opc", {60'b0, alu_opcode}, 64'd0);
    q.delete();
    m_icc = 4'b0000;
    @(negedge Clk);
    Clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      chk("abort_silent", {63'b0, rsp_valid}, 64'd0);
    end
    send(4'b0000, 1'b0, 64'h5, 64'h7);
    get_rsp(0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issue controller for the 32-bit mini ALU.
- Accepts operation requests over a valid/ready handshake and drives the ALU opcode and operands.
- Double-width (64-bit) requests run as two ALU passes, low word then high word, with internal carry/borrow chaining.
- Generates and holds the integer condition codes (N, Z, V, C), which the ALU does not produce, and returns the result over a valid/ready response channel.

Parameters:
- W, 32, ALU word width. The double-width result is 2*W.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Clr  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  ALU opcode, using the mini ALU encoding.
- req_dbl  in  1  1 = 64-bit operation.
- req_a  in  2W  operand A; single-width uses [W-1:0].
- req_b  in  2W  operand B; single-width uses [W-1:0].
- alu_a  out  W  ALU operand a.
- alu_b  out  W  ALU operand b.
- alu_c1  out  1  ALU carry-in.
- alu_opcode  out  4  ALU opcode.
- alu_y  in  W  ALU result; combinational from alu_* in the same cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  2W  result; upper W bits are 0 for single-width.
- rsp_err  out  1  request rejected.
- icc  out  4  {N,Z,V,C}, registered.

Behaviour:
- States: IDLE, EXEC_LO, EXEC_HI, RESP.
- Reset:
  - Clr=1 forces state IDLE immediately, from any state including mid-operation.
  - Clearing: rsp_valid=0, rsp_err=0, rsp_y=0, icc=0, latched operands=0, internal carry=0, alu_opcode=0, alu_a=0, alu_b=0, alu_c1=0.
  - An aborted request is dropped; it produces no response and no icc update.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted on an edge where req_valid & req_ready. Operands and opcode are latched at that edge.
  - In RESP, rsp_valid=1 and rsp_y, rsp_err are held stable until the edge with rsp_ready=1; then the state goes to IDLE.
  - Back-to-back requests are not overlapped. Minimum request spacing is 3 cycles single-width, 4 cycles double-width.
- IDLE -> EXEC_LO on accept, except for an illegal request, which goes IDLE -> RESP directly with rsp_err=1, rsp_y=0 and icc unchanged.
  - Illegal request: req_dbl=1 with req_op in 1010..1100 (shifts).
- EXEC_LO:
  - alu_a=A[W-1:0], alu_b=B[W-1:0], alu_opcode=op.
  - alu_c1 = icc.C for op 0001/0011, else 0.
  - At the edge: capture alu_y into rsp_y[W-1:0] and compute carry_lo.
  - Next state: EXEC_HI if dbl, else RESP.
- EXEC_HI:
  - alu_a=A[2W-1:W], alu_b=B[2W-1:W].
  - For ops 0000/0001, alu_opcode=0001 with alu_c1=carry_lo. For ops 0010/0011, alu_opcode=0011 with alu_c1=carry_lo.
  - All other ops pass op through with alu_c1=0.
  - At the edge: capture alu_y into rsp_y[2W-1:W]. Next state: RESP.
- In states other than EXEC_LO/EXEC_HI, alu_* are driven to 0.
- Carry/borrow, computed on the current pass, with a, b, c1 = the values driven that pass and y = alu_y:
  - Add (0000/0001): cout = (y < a) | (c1 & (y == a)).
  - Sub (0010/0011): cout = (a < b) | (c1 & (a == b)).
  - cout for other ops = 0.
- icc is updated on the edge entering RESP, for non-error requests only:
  - N = msb of the final result (bit W-1 for single-width, bit 2W-1 for double-width).
  - Z = 1 if the full result width is 0.
  - C = cout of the last pass.
  - V (add) = (a_msb == b_msb) & (y_msb != a_msb) on the last pass.
  - V (sub) = (a_msb != b_msb) & (y_msb != a_msb) on the last pass.
  - V = 0 and C = 0 for non-arithmetic ops.
- Logic, move and not ops run per word with no chaining. Their result is whatever the ALU returns for each word.
- All widths are unsigned modular; no saturation.

Decomposition:
- Package alu_seq_pkg:
  - Opcode constants: OP_ADD=0000, OP_ADDX=0001, OP_SUB=0010, OP_SUBX=0011, OP_SLL=1010, OP_SRL=1011, OP_SRA=1100.
  - State encoding: IDLE=00, EXEC_LO=01, EXEC_HI=10, RESP=11.
  - ICC bit indices: N=3, Z=2, V=1, C=0.
- Sub-module alu_flag_gen: combinational; takes opcode, a, b, c1, y and returns cout, v.

Test Plan:
- Single add:
  - Stimulus: op=0000, A=5, B=7, dbl=0.
  - Response: rsp_valid 2 cycles after accept, rsp_y=12, icc=0000.
- Double add with carry chain:
  - Stimulus: A=0x00000000_FFFFFFFF, B=1, dbl=1.
  - Response: rsp_y=0x00000001_00000000, icc=0000; EXEC_HI drives alu_opcode=0001 with alu_c1=1.
- Single sub with borrow, then extended add using the stored carry:
  - Stimulus: sub 0-1, then op=0001, A=2, B=3.
  - Response: first result rsp_y=0xFFFFFFFF, icc=1001 (N=1, C=1). Second result rsp_y=6 (alu_c1=icc.C=1).
- Illegal request plus backpressure:
  - Stimulus: op=1010 with dbl=1, rsp_ready held low for 5 cycles.
  - Response: rsp_err=1, rsp_y=0, icc unchanged; rsp_valid held for all 5 cycles and req_ready=0 throughout.
- Signed overflow:
  - Stimulus: single add 0x7FFFFFFF+1.
  - Response: rsp_y=0x80000000, icc=1010 (N=1, V=1).
- Reset mid-operation:
  - Stimulus: assert Clr during EXEC_HI of a double-width op.
  - Response: immediately state IDLE, rsp_valid=0, icc=0. No response is ever issued for the aborted request; the next request completes normally.
